hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the stall, flush and forward controls for the F/D, D/E (reg_e) and E/M pipeline registers.
- Resolves load-use and branch hazards, and selects forwarding paths for the D and E stages.
- Sequences a multi-cycle multiply/divide unit in EX: holds the pipeline until the operation completes.

Parameters:
MULT_CYCLES  4   EX occupancy of mult/multu in cycles (must be >=2)
DIV_CYCLES   32  EX occupancy of div/divu in cycles (must be >=2)
CNT_W        6   width of the occupancy counter (must hold DIV_CYCLES-1)

Ports:
clk            in   1  clock, rising edge
clr            in   1  synchronous active-high reset
rs_d, rt_d     in   5  source register numbers in D
rs_e, rt_e     in   5  source register numbers in E
write_reg_e    in   5  destination register in E
write_reg_m    in   5  destination register in M
write_reg_w    in   5  destination register in W
reg_write_e    in   1  E-stage instruction writes the register file
reg_write_m    in   1  M-stage instruction writes the register file
reg_write_w    in   1  W-stage instruction writes the register file
mem_to_reg_e   in   1  E-stage instruction is a load
mem_to_reg_m   in   1  M-stage instruction is a load
branch_d       in   1  D-stage instruction is beq/bne
md_start_e     in   1  E holds a mult/div instruction
md_div_e       in   1  1 = div, 0 = mult (valid with md_start_e)
stall_f        out  1  hold the PC
stall_d        out  1  hold the F/D register
stall_e        out  1  hold the D/E register
flush_e        out  1  clear the D/E register (bubble)
flush_m        out  1  clear the E/M register (bubble)
forward_a_d    out  1  D-stage rs comparator takes the M-stage ALU result
forward_b_d    out  1  D-stage rt comparator takes the M-stage ALU result
forward_a_e    out  2  E-stage srcA mux select
forward_b_e    out  2  E-stage srcB mux select
md_busy        out  1  multiply/divide sequence in progress
md_done        out  1  final cycle of the multiply/divide operation

Behaviour:
- Forwarding (combinational):
  - forward_a_e = 2'b10 if rs_e!=0 && rs_e==write_reg_m && reg_write_m.
  - Otherwise forward_a_e = 2'b01 if rs_e!=0 && rs_e==write_reg_w && reg_write_w.
  - Otherwise forward_a_e = 2'b00. M beats W when both match.
  - forward_b_e: same rules using rt_e.
  - forward_a_d = rs_d!=0 && rs_d==write_reg_m && reg_write_m.
  - forward_b_d: same rule using rt_d.
- lw_stall = mem_to_reg_e && (rt_e==rs_d || rt_e==rt_d).
- br_stall = branch_d && ((reg_write_e && write_reg_e in {rs_d,rt_d}) || (mem_to_reg_m && write_reg_m in {rs_d,rt_d})).
- FSM states:
  - IDLE: 2'b00, counter cnt = 0.
  - RUN: 2'b01.
- N = DIV_CYCLES if md_div_e, else MULT_CYCLES.
- Transitions:
  - IDLE with md_start_e: md_stall=1, cnt<=N-2, go to RUN.
  - RUN with cnt!=0: md_stall=1, cnt<=cnt-1.
  - RUN with cnt==0: md_stall=0, md_done=1, go to IDLE.
  - The mult/div instruction therefore occupies EX for exactly N cycles and advances on the edge ending the md_done cycle.
  - md_start_e seen in RUN does not restart the counter (the same instruction is still held in EX).
  - md_start_e in the IDLE cycle right after md_done starts a new operation.
- md_busy = md_stall.
- Output combination:
  - stall_f = stall_d = lw_stall | br_stall | md_stall.
  - stall_e = md_stall.
  - flush_m = md_stall.
  - flush_e = (lw_stall | br_stall) & ~md_stall. During md_stall, EX must be held, not bubbled.
- Reset:
  - clr=1 at an edge: state<=IDLE, cnt<=0.
  - During any cycle with clr=1, all outputs are forced to 0, including the forwards.
  - clr mid-RUN abandons the operation; md_done is not pulsed.
  - Outputs after reset: all 0 until inputs create a hazard.
- Reg 0 never forwards; it may still trigger lw_stall (harmless, kept for simplicity).

Test Plan:
1. write_reg_m=5, reg_write_m=1, write_reg_w=5, reg_write_w=1, rs_e=5, rt_e=0 -> forward_a_e=10, forward_b_e=00. Set rs_e=0 -> forward_a_e=00.
2. mem_to_reg_e=1, rt_e=8, rs_d=8 -> stall_f=stall_d=flush_e=1 for one cycle. Drop mem_to_reg_e -> all 0.
3. branch_d=1, reg_write_e=1, write_reg_e=9, rt_d=9 -> stall_f=stall_d=flush_e=1. Move the writer to M as ALU op (mem_to_reg_m=0) -> no stall, forward_b_d=1.
4. md_start_e=1, md_div_e=0, held -> stall_e/flush_m/md_busy=1 for cycles 1-3, md_done=1 in cycle 4, IDLE in cycle 5.
5. md_div_e=1 -> md_busy=1 for 31 cycles, md_done in cycle 32. A coincident lw_stall during RUN -> flush_e stays 0.
6. clr=1 at cycle 10 of a divide -> all outputs 0 that cycle, IDLE next cycle, no md_done. Restart with mult -> 4-cycle sequence.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard-unit signal bundle between the pipeline datapath and hazard_ctrl.
//   slave  : seen by hazard_ctrl (register numbers/controls in, stall/flush/forward out)
//   master : seen by the pipeline (drives register numbers/controls, receives stall/flush/forward)
interface hazard_ctrl_if;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, reg_write_m, reg_write_w;
    logic       mem_to_reg_e, mem_to_reg_m, branch_d;
    logic       md_start_e, md_div_e;
    logic       stall_f, stall_d, stall_e, flush_e, flush_m;
    logic       forward_a_d, forward_b_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic       md_busy, md_done;

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               branch_d, md_start_e, md_div_e,
        output stall_f, stall_d, stall_e, flush_e, flush_m, forward_a_d, forward_b_d,
               forward_a_e, forward_b_e, md_busy, md_done
    );

    modport master (
        output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               branch_d, md_start_e, md_div_e,
        input  stall_f, stall_d, stall_e, flush_e, flush_m, forward_a_d, forward_b_d,
               forward_a_e, forward_b_e, md_busy, md_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage MIPS hazard unit (forwarding, load-use/branch stalls, mult/div sequencing).
//   clk : rising-edge clock
//   clr : synchronous active-high reset; forces every output to 0 in its cycle
//   h   : hazard_ctrl_if.slave bundle (register numbers/controls in, stall/flush/forward out)
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic          clk,
    input  logic          clr,
    hazard_ctrl_if.slave  h
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01} state_t;

    // The start cycle counts as one and the done cycle as one, hence N-2.
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_stall, md_fin, lw_stall, br_stall, hz;
    logic [1:0]       fa_e, fb_e;
    logic             fa_d, fb_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_stall = 1'b0;
        md_fin   = 1'b0;
        if (state_q == IDLE) begin
            if (h.md_start_e) begin
                md_stall = 1'b1;
                cnt_d    = h.md_div_e ? DIV_LD : MULT_LD;
                state_d  = RUN;
            end
        end else if (cnt_q != '0) begin
            md_stall = 1'b1;
            cnt_d    = cnt_q - 1'b1;
        end else begin
            md_fin  = 1'b1;
            state_d = IDLE;
        end
    end

    // Register 0 is hard-wired zero, so it never forwards.
    assign fa_e = (h.rs_e != 5'd0 && h.rs_e == h.write_reg_m && h.reg_write_m) ? 2'b10 :
                  (h.rs_e != 5'd0 && h.rs_e == h.write_reg_w && h.reg_write_w) ? 2'b01 : 2'b00;
    assign fb_e = (h.rt_e != 5'd0 && h.rt_e == h.write_reg_m && h.reg_write_m) ? 2'b10 :
                  (h.rt_e != 5'd0 && h.rt_e == h.write_reg_w && h.reg_write_w) ? 2'b01 : 2'b00;
    assign fa_d = h.rs_d != 5'd0 && h.rs_d == h.write_reg_m && h.reg_write_m;
    assign fb_d = h.rt_d != 5'd0 && h.rt_d == h.write_reg_m && h.reg_write_m;

    assign lw_stall = h.mem_to_reg_e && (h.rt_e == h.rs_d || h.rt_e == h.rt_d);
    assign br_stall = h.branch_d &&
                      ((h.reg_write_e  && (h.write_reg_e == h.rs_d || h.write_reg_e == h.rt_d)) ||
                       (h.mem_to_reg_m && (h.write_reg_m == h.rs_d || h.write_reg_m == h.rt_d)));
    assign hz = lw_stall | br_stall;

    assign h.stall_f     = ~clr & (hz | md_stall);
    assign h.stall_d     = ~clr & (hz | md_stall);
    assign h.stall_e     = ~clr & md_stall;
    assign h.flush_m     = ~clr & md_stall;
    // EX is held, not bubbled, while the mult/div occupies it.
    assign h.flush_e     = ~clr & hz & ~md_stall;
    assign h.forward_a_d = ~clr & fa_d;
    assign h.forward_b_d = ~clr & fb_d;
    assign h.forward_a_e = clr ? 2'b00 : fa_e;
    assign h.forward_b_e = clr ? 2'b00 : fb_e;
    assign h.md_busy     = ~clr & md_stall;
    assign h.md_done     = ~clr & md_fin;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (directed scenarios plus random traffic).
module tb_hazard_ctrl;
    localparam int MULT = 4;
    localparam int DIV  = 32;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   md_left = 0;
    logic [13:0] exp_q[$];
    string       tag_q[$];
    logic [13:0] outv;

    hazard_ctrl_if hif();

    hazard_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(6)) dut (
        .clk(clk),
        .clr(clr),
        .h  (hif.slave)
    );

    always #5 clk = ~clk;

    assign outv = {hif.stall_f, hif.stall_d, hif.stall_e, hif.flush_e, hif.flush_m,
                   hif.forward_a_d, hif.forward_b_d, hif.forward_a_e, hif.forward_b_e,
                   hif.md_busy, hif.md_done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic zero();
        hif.rs_d = 0; hif.rt_d = 0; hif.rs_e = 0; hif.rt_e = 0;
        hif.write_reg_e = 0; hif.write_reg_m = 0; hif.write_reg_w = 0;
        hif.reg_write_e = 0; hif.reg_write_m = 0; hif.reg_write_w = 0;
        hif.mem_to_reg_e = 0; hif.mem_to_reg_m = 0; hif.branch_d = 0;
        hif.md_start_e = 0; hif.md_div_e = 0;
    endtask

    // Model the current cycle from the present inputs, queue the expectation,
    // compare on the falling edge, then advance the model on the rising edge.
    task automatic cyc(input string tag);
        logic [1:0] fa, fb;
        logic fad, fbd, lw, br, ms, dn;
        int cur, nxt;
        fa  = (hif.rs_e != 0 && hif.rs_e == hif.write_reg_m && hif.reg_write_m) ? 2'd2 :
              (hif.rs_e != 0 && hif.rs_e == hif.write_reg_w && hif.reg_write_w) ? 2'd1 : 2'd0;
        fb  = (hif.rt_e != 0 && hif.rt_e == hif.write_reg_m && hif.reg_write_m) ? 2'd2 :
              (hif.rt_e != 0 && hif.rt_e == hif.write_reg_w && hif.reg_write_w) ? 2'd1 : 2'd0;
        fad = hif.rs_d != 0 && hif.rs_d == hif.write_reg_m && hif.reg_write_m;
        fbd = hif.rt_d != 0 && hif.rt_d == hif.write_reg_m && hif.reg_write_m;
        lw  = hif.mem_to_reg_e && (hif.rt_e == hif.rs_d || hif.rt_e == hif.rt_d);
        br  = hif.branch_d &&
              ((hif.reg_write_e && (hif.write_reg_e == hif.rs_d || hif.write_reg_e == hif.rt_d)) ||
               (hif.mem_to_reg_m && (hif.write_reg_m == hif.rs_d || hif.write_reg_m == hif.rt_d)));
        cur = (md_left == 0 && hif.md_start_e) ? (hif.md_div_e ? DIV : MULT) : md_left;
        ms  = cur > 1;
        dn  = cur == 1;
        nxt = cur > 0 ? cur - 1 : 0;
        if (clr) begin
            exp_q.push_back('0);
            nxt = 0;
        end else begin
            exp_q.push_back({lw | br | ms, lw | br | ms, ms, (lw | br) & ~ms, ms,
                             fad, fbd, fa, fb, ms, dn});
        end
        tag_q.push_back(tag);
        @(negedge clk);
        check(tag_q.pop_front(), 32'(outv), 32'(exp_q.pop_front()));
        @(posedge clk);
        md_left = nxt;
        #1;
    endtask

    initial begin
        zero();
        hif.rs_e = 5; hif.write_reg_m = 5; hif.reg_write_m = 1;
        hif.md_start_e = 1;
        cyc("reset_forced_zero");
        cyc("reset_forced_zero2");
        clr = 0;
        zero();
        cyc("after_reset_idle");
        // forwarding priority and register 0
        hif.write_reg_m = 5; hif.reg_write_m = 1; hif.write_reg_w = 5; hif.reg_write_w = 1;
        hif.rs_e = 5; hif.rt_e = 0;
        cyc("fwd_m_beats_w");
        hif.rs_e = 0;
        cyc("fwd_reg0");
        hif.rs_e = 5; hif.rt_e = 5; hif.reg_write_m = 0;
        cyc("fwd_w_only");
        zero();
        // load-use
        hif.mem_to_reg_e = 1; hif.rt_e = 8; hif.rs_d = 8;
        cyc("lw_stall");
        hif.mem_to_reg_e = 0;
        cyc("lw_clear");
        zero();
        // branch hazard, then ALU writer in M forwards
        hif.branch_d = 1; hif.reg_write_e = 1; hif.write_reg_e = 9; hif.rt_d = 9;
        cyc("br_stall_e");
        hif.reg_write_e = 0; hif.write_reg_e = 0;
        hif.reg_write_m = 1; hif.write_reg_m = 9; hif.mem_to_reg_m = 0;
        cyc("br_fwd_m");
        hif.mem_to_reg_m = 1;
        cyc("br_stall_load_m");
        zero();
        // multiply: 3 stall cycles, done in the 4th
        hif.md_start_e = 1; hif.md_div_e = 0;
        for (int i = 1; i <= MULT; i++) cyc($sformatf("mult_c%0d", i));
        hif.md_start_e = 0;
        cyc("mult_idle");
        // divide with a coincident load-use during RUN
        hif.md_start_e = 1; hif.md_div_e = 1;
        for (int i = 1; i <= DIV; i++) begin
            hif.mem_to_reg_e = (i == 5); hif.rt_e = 3; hif.rs_d = 3;
            cyc($sformatf("div_c%0d", i));
        end
        zero();
        cyc("div_idle");
        // reset during a divide abandons it
        hif.md_start_e = 1; hif.md_div_e = 1;
        for (int i = 1; i <= 9; i++) cyc($sformatf("divclr_c%0d", i));
        clr = 1;
        cyc("divclr_c10_clr");
        clr = 0; hif.md_start_e = 0;
        cyc("divclr_idle");
        cyc("divclr_no_done");
        hif.md_start_e = 1; hif.md_div_e = 0;
        for (int i = 1; i <= MULT; i++) cyc($sformatf("remult_c%0d", i));
        zero();
        cyc("remult_idle");
        // random traffic on a small register range to force collisions
        for (int i = 0; i < 400; i++) begin
            hif.rs_d = 5'($urandom_range(0, 3)); hif.rt_d = 5'($urandom_range(0, 3));
            hif.rs_e = 5'($urandom_range(0, 3)); hif.rt_e = 5'($urandom_range(0, 3));
            hif.write_reg_e = 5'($urandom_range(0, 3));
            hif.write_reg_m = 5'($urandom_range(0, 3));
            hif.write_reg_w = 5'($urandom_range(0, 3));
            hif.reg_write_e = 1'($urandom); hif.reg_write_m = 1'($urandom);
            hif.reg_write_w = 1'($urandom);
            hif.mem_to_reg_e = 1'($urandom); hif.mem_to_reg_m = 1'($urandom);
            hif.branch_d = 1'($urandom);
            hif.md_start_e = ($urandom_range(0, 5) == 0);
            hif.md_div_e = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 60) == 0);
            cyc($sformatf("rand_%0d", i));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
